// File: rtl/fp_extremum_track_if.sv
// rtl/fp_extremum_track_if.sv - operand stream in, result out, for fp_extremum_track
//
// Purpose: groups the operand beat handshake, its sideband ordering controls
// and the result handshake into one bundle.
// Ports (master = stream source / result sink, slave = fp_extremum_track):
//   mode, sel_max                 ordering controls, sampled on the first beat
//   in_valid/in_ready/in_data/in_last   operand beats
//   out_valid/out_ready           result handshake
//   out_data/out_index/out_count  winning operand, its beat position, beat count
interface fp_extremum_track_if #(
  parameter int WIDTH = 32
);
  logic             mode;
  logic             sel_max;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [15:0]      out_index;
  logic [15:0]      out_count;

  modport master (
    output mode, sel_max, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_count
  );

  modport slave (
    input  mode, sel_max, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_index, out_count
  );
endinterface

// File: rtl/fp_extremum_track.sv
// rtl/fp_extremum_track.sv - running min/max of a floating-point operand stream
//
// Purpose: consumes a stream of operands and reports the extremum (min or max,
// raw-unsigned or signed sign/magnitude ordering), its zero-based beat position
// and the number of beats in the stream.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  fp_extremum_track_if.slave (operand stream in, result out)
module fp_extremum_track #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int BIAS      = 127
) (
  input  logic                clk,
  input  logic                rst,
  fp_extremum_track_if.slave  bus
);

  localparam int MAG_W = EXP_WIDTH + MAN_WIDTH;

  // The field layout must tile the word exactly; the bias is only sanity-checked.
  if (MAG_W + 1 != WIDTH || BIAS < 0) begin : g_bad_params
    $error("fp_extremum_track: inconsistent field parameters");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] best_q, best_d;
  logic [15:0]      idx_q, idx_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             max_q, max_d;
  logic [WIDTH-1:0] od_q, od_d;
  logic [15:0]      oi_q, oi_d;
  logic [15:0]      oc_q, oc_d;

  logic             accept;
  logic             better;
  logic [15:0]      cnt_inc;

  // a > b under the selected ordering. In signed mode the sign bit decides
  // first (so +0 beats -0); same-sign operands compare by magnitude, reversed
  // for negatives. NaN/Inf are not special: they fall out of the bit patterns.
  function automatic logic greater(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b,
                                   input logic             signed_order);
    logic [MAG_W-1:0] mag_a;
    logic [MAG_W-1:0] mag_b;
    mag_a = a[MAG_W-1:0];
    mag_b = b[MAG_W-1:0];
    if (!signed_order)
      return a > b;
    else if (a[WIDTH-1] != b[WIDTH-1])
      return !a[WIDTH-1];
    else if (!a[WIDTH-1])
      return mag_a > mag_b;
    else
      return mag_a < mag_b;
  endfunction

  assign accept  = bus.in_valid && (state_q != DONE);
  // Ties are never "better", which keeps the earliest equal beat.
  assign better  = max_q ? greater(bus.in_data, best_q, mode_q)
                         : greater(best_q, bus.in_data, mode_q);
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    best_d  = best_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    max_d   = max_q;
    od_d    = od_q;
    oi_d    = oi_q;
    oc_d    = oc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          best_d  = bus.in_data;
          idx_d   = 16'd0;
          cnt_d   = 16'd1;
          mode_d  = bus.mode;
          max_d   = bus.sel_max;
          state_d = bus.in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (better) begin
            best_d = bus.in_data;
            // Zero-based position of this beat is the count before it (saturated).
            idx_d  = cnt_q;
          end
          cnt_d = cnt_inc;
          if (bus.in_last) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Result registers load only when a stream closes, so they hold the last
    // result through DONE and afterwards.
    if (accept && bus.in_last) begin
      od_d = best_d;
      oi_d = idx_d;
      oc_d = cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      best_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      max_q   <= 1'b0;
      od_q    <= '0;
      oi_q    <= '0;
      oc_q    <= '0;
    end else begin
      state_q <= state_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      max_q   <= max_d;
      od_q    <= od_d;
      oi_q    <= oi_d;
      oc_q    <= oc_d;
    end
  end

  assign bus.in_ready  = (state_q != DONE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = od_q;
  assign bus.out_index = oi_q;
  assign bus.out_count = oc_q;

endmodule

// File: tb/tb_fp_extremum_track.sv
// tb/tb_fp_extremum_track.sv - self-checking bench for fp_extremum_track
module tb_fp_extremum_track;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_extremum_track_if #(.WIDTH(32)) bus ();

  fp_extremum_track #(
    .WIDTH(32), .EXP_WIDTH(8), .MAN_WIDTH(23), .BIAS(127)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  logic [31:0] vec [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Ordering key: a plain integer whose natural order is the required order.
  // Signed mode maps -x to -(mag)-1 so that -0 sits just below +0.
  function automatic longint key(input logic [31:0] v, input bit signed_order);
    longint mag;
    if (!signed_order) return {32'd0, v};
    mag = {33'd0, v[30:0]};
    return v[31] ? -mag - 1 : mag;
  endfunction

  // Transaction-level model: collect the stream's beats, pick the winner at the end.
  logic [31:0] beats[$];
  bit          m_mode, m_max;
  bit          exp_valid = 1'b0;
  logic [31:0] exp_data  = '0;
  logic [15:0] exp_index = '0;
  logic [15:0] exp_count = '0;

  always @(posedge clk) begin
    bit was_valid;
    int win;
    if (rst) begin
      beats.delete();
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_index = '0;
      exp_count = '0;
    end else begin
      was_valid = exp_valid;
      if (was_valid && bus.out_ready) exp_valid = 1'b0;
      if (bus.in_valid && !was_valid) begin
        if (beats.size() == 0) begin
          m_mode = bus.mode;
          m_max  = bus.sel_max;
        end
        beats.push_back(bus.in_data);
        if (bus.in_last) begin
          win = 0;
          for (int i = 1; i < beats.size(); i++) begin
            if (m_max ? key(beats[i], m_mode) > key(beats[win], m_mode)
                      : key(beats[i], m_mode) < key(beats[win], m_mode))
              win = i;
          end
          exp_data  = beats[win];
          exp_index = 16'(win);
          exp_count = (beats.size() > 65535) ? 16'hFFFF : 16'(beats.size());
          exp_valid = 1'b1;
          beats.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc_in_ready",  {31'd0, bus.in_ready},  {31'd0, !exp_valid});
      check("cyc_out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
      check("cyc_out_data",  bus.out_data, exp_data);
      check("cyc_out_index", {16'd0, bus.out_index}, {16'd0, exp_index});
      check("cyc_out_count", {16'd0, bus.out_count}, {16'd0, exp_count});
    end
  end

  // Drives n beats from vec; optional idle gap with junk data/last between beats,
  // optional mode flip after the first beat (must be ignored).
  task automatic send(input bit m, input bit mx, input int n, input bit gap, input bit flip);
    for (int i = 0; i < n; i++) begin
      bus.mode     = (flip && i > 0) ? ~m : m;
      bus.sel_max  = (flip && i > 0) ? ~mx : mx;
      bus.in_valid = 1'b1;
      bus.in_data  = vec[i];
      bus.in_last  = (i == n - 1);
      @(negedge clk);
      if (gap && i < n - 1) begin
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.in_last  = 1'b1;
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("valid_one_cycle_after_last", {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("in_ready_after_handshake", {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic expect_result(input string name, input logic [31:0] d,
                               input logic [15:0] idx, input logic [15:0] cnt);
    check({name, "_data"},  bus.out_data, d);
    check({name, "_index"}, {16'd0, bus.out_index}, {16'd0, idx});
    check({name, "_count"}, {16'd0, bus.out_count}, {16'd0, cnt});
  endtask

  initial begin
    bus.mode = 1'b0; bus.sel_max = 1'b0; bus.in_valid = 1'b0;
    bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    expect_result("reset", 32'h0, 16'd0, 16'd0);
    rst = 1'b0;
    started = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

    vec[0] = 32'h3F800000; vec[1] = 32'hC0000000; vec[2] = 32'h40400000;
    send(1'b1, 1'b1, 3, 1'b0, 1'b0);
    expect_result("signed_max", 32'h40400000, 16'd2, 16'd3);
    consume();
    send(1'b0, 1'b0, 3, 1'b0, 1'b0);
    expect_result("raw_min", 32'h3F800000, 16'd0, 16'd3);
    consume();
    send(1'b1, 1'b0, 3, 1'b0, 1'b0);
    expect_result("signed_min", 32'hC0000000, 16'd1, 16'd3);
    consume();

    vec[0] = 32'h80000000; vec[1] = 32'h00000000;
    send(1'b1, 1'b1, 2, 1'b0, 1'b0);
    expect_result("pos_zero_beats_neg_zero", 32'h00000000, 16'd1, 16'd2);
    consume();

    vec[0] = 32'h40000000; vec[1] = 32'h40000000;
    send(1'b1, 1'b1, 2, 1'b0, 1'b0);
    expect_result("tie_keeps_first", 32'h40000000, 16'd0, 16'd2);
    consume();

    vec[0] = 32'h12345678;
    send(1'b0, 1'b1, 1, 1'b0, 1'b0);
    expect_result("single", 32'h12345678, 16'd0, 16'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      expect_result("stall_hold", 32'h12345678, 16'd0, 16'd1);
    end
    consume();

    // Mid-stream control flips and idle gaps with junk must not matter.
    vec[0] = 32'hBF800000; vec[1] = 32'h3F800000; vec[2] = 32'hC0400000;
    send(1'b1, 1'b1, 3, 1'b1, 1'b1);
    expect_result("flip_ignored", 32'h3F800000, 16'd1, 16'd3);
    consume();

    vec[0] = 32'hBF800000; vec[1] = 32'hC0400000; vec[2] = 32'hC0000000; vec[3] = 32'h80000000;
    send(1'b1, 1'b0, 4, 1'b0, 1'b0);
    expect_result("neg_min", 32'hC0400000, 16'd1, 16'd4);
    consume();

    // Abort a four-beat stream after two beats; reset beats a concurrent handshake.
    bus.mode = 1'b1; bus.sel_max = 1'b1;
    bus.in_valid = 1'b1; bus.in_last = 1'b0;
    bus.in_data = 32'h40000000; @(negedge clk);
    bus.in_data = 32'h40400000; @(negedge clk);
    bus.in_data = 32'h41000000; bus.in_last = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    expect_result("abort", 32'h0, 16'd0, 16'd0);
    @(negedge clk);
    check("abort_out_valid_later", {31'd0, bus.out_valid}, 32'd0);
    vec[0] = 32'h40A00000;
    send(1'b1, 1'b1, 1, 1'b0, 1'b0);
    expect_result("after_abort", 32'h40A00000, 16'd0, 16'd1);
    consume();

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_extremum_track.md
FP_EXTREMUM_TRACK -- requirements
Module: fp_extremum_track

Interface
REQ-001 Parameter WIDTH, default 32: total operand width in bits.
REQ-002 Parameter EXP_WIDTH, default 8: exponent field width.
REQ-003 Parameter MAN_WIDTH, default 23: mantissa field width; sign is bit WIDTH-1.
REQ-004 Parameter BIAS, default 127: exponent bias; carried for consistency and unused functionally.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 mode  input  1  ordering: 0 = raw unsigned bit pattern, 1 = signed IEEE-style order; sampled on the first beat only.
REQ-009 sel_max  input  1  1 = track maximum, 0 = track minimum; sampled on the first beat only.
REQ-010 in_valid  input  1  operand beat valid.
REQ-011 in_ready  output  1  block accepts a beat when in_valid and in_ready are both high.
REQ-012 in_data  input  WIDTH  operand.
REQ-013 in_last  input  1  marks the final beat of a stream.
REQ-014 out_valid  output  1  result valid.
REQ-015 out_ready  input  1  result consumed when out_valid and out_ready are both high.
REQ-016 out_data  output  WIDTH  winning operand.
REQ-017 out_index  output  16  zero-based beat position of the winner.
REQ-018 out_count  output  16  number of beats accepted in the stream.

Function
REQ-019 FSM states SHALL be IDLE, ACCUM and DONE; in_ready = 1 in IDLE and ACCUM, 0 in DONE; out_valid = 1 only in DONE.
REQ-020 IDLE, beat accepted: best <= in_data, index <= 0, count <= 1, mode and sel_max latched; next state is DONE if in_last, else ACCUM.
REQ-021 ACCUM, beat accepted: compare in_data (a) against best (b); replace best and set index <= count only if a is strictly better; count <= count+1; go to DONE if in_last.
REQ-022 Mode 0 ordering: a > b iff {exponent,mantissa} incl. sign bit compared as a WIDTH-bit unsigned value is greater.
REQ-023 Mode 1 ordering: signs differ -> the operand with sign 0 is greater (so +0 > -0); both positive -> larger magnitude is greater; both negative -> smaller magnitude is greater; equal bit patterns are equal.
REQ-024 No NaN/infinity special-casing; these are ordered purely by REQ-022/023.
REQ-025 "Strictly better" = greater when max latched, lesser when min latched; ties keep the earlier beat.
REQ-026 count SHALL saturate at 16'hFFFF; index records the saturated count value.
REQ-027 out_valid SHALL rise the cycle after the in_last beat is accepted (1-cycle latency).
REQ-028 DONE: out_data/out_index/out_count stable while out_valid and not out_ready; on handshake go to IDLE with in_ready high the next cycle.
REQ-029 out_data/out_index/out_count SHALL hold the last result after leaving DONE until a new result is produced.
REQ-030 in_data and in_last are ignored on cycles with no accepted beat; changes to mode/sel_max mid-stream have no effect.

Reset
REQ-031 When rst is high at a clock edge: state <= IDLE, out_valid <= 0, out_data <= 0, out_index <= 0, out_count <= 0, internal best/count cleared; in_ready is 1 the cycle after rst falls.
REQ-032 Reset SHALL take priority over any handshake in the same cycle and abort a stream in progress with no result emitted.

Verification
REQ-033 mode=1, sel_max=1, beats 3F800000, C0000000, 40400000(last) -> out_data=40400000, out_index=2, out_count=3, out_valid one cycle after last.
REQ-034 Same beats, mode=0, sel_max=0 -> out_data=3F800000, out_index=0; mode=1, sel_max=0 -> out_data=C0000000, out_index=1.
REQ-035 mode=1, sel_max=1, beats 80000000, 00000000(last) -> out_data=00000000, out_index=1; beats 40000000, 40000000(last) -> out_index=0 (tie keeps earliest).
REQ-036 Single beat 12345678 with in_last -> out_data=12345678, out_index=0, out_count=1; hold out_ready low 3 cycles -> outputs stable, in_ready=0 throughout.
REQ-037 Assert rst after two beats of a four-beat stream -> out_valid stays 0, outputs 0; new stream 40A00000(last) -> out_count=1, out_data=40A00000.
